// File: rtl/menshen_arb_pkg.sv
// menshen_arb_pkg: shared state encoding and constants for the Menshen config arbiter
package menshen_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    DRAIN = 2'd2,
    CFG   = 2'd3
  } arb_state_t;
  localparam logic [15:0] CFG_UDP_PORT = 16'hf2f1;
endpackage

// File: rtl/menshen_arb_stats.sv
// menshen_arb_stats: packet and drain-cycle counters, present only with MENSHEN_ARB_STATS_EN
//   clk, rst_n            : clock, async active-low reset
//   data_last, cfg_last   : last-beat handshake strobes per source
//   drain                 : high on each DRAIN cycle
//   *_cnt                 : free-running wrapping counters
`ifdef MENSHEN_ARB_STATS_EN
module menshen_arb_stats #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_last,
  input  logic             cfg_last,
  input  logic             drain,
  output logic [CNT_W-1:0] data_pkt_cnt,
  output logic [CNT_W-1:0] cfg_pkt_cnt,
  output logic [CNT_W-1:0] drain_cyc_cnt
);
  logic [CNT_W-1:0] data_pkt_cnt_q, data_pkt_cnt_d;
  logic [CNT_W-1:0] cfg_pkt_cnt_q, cfg_pkt_cnt_d;
  logic [CNT_W-1:0] drain_cyc_cnt_q, drain_cyc_cnt_d;
  always_comb begin
    data_pkt_cnt_d  = data_last ? data_pkt_cnt_q + CNT_W'(1) : data_pkt_cnt_q;
    cfg_pkt_cnt_d   = cfg_last ? cfg_pkt_cnt_q + CNT_W'(1) : cfg_pkt_cnt_q;
    drain_cyc_cnt_d = drain ? drain_cyc_cnt_q + CNT_W'(1) : drain_cyc_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_pkt_cnt_q  <= '0;
      cfg_pkt_cnt_q   <= '0;
      drain_cyc_cnt_q <= '0;
    end else begin
      data_pkt_cnt_q  <= data_pkt_cnt_d;
      cfg_pkt_cnt_q   <= cfg_pkt_cnt_d;
      drain_cyc_cnt_q <= drain_cyc_cnt_d;
    end
  end
  assign data_pkt_cnt  = data_pkt_cnt_q;
  assign cfg_pkt_cnt   = cfg_pkt_cnt_q;
  assign drain_cyc_cnt = drain_cyc_cnt_q;
endmodule
`endif

// File: rtl/menshen_cfg_arbiter.sv
// menshen_cfg_arbiter: packet-level AXIS arbiter merging data and reconfiguration streams
//   axis_aclk, aresetn : clock, async active-low reset
//   s_data_*, s_cfg_*  : AXIS sources (data packets / config packets)
//   m_axis_*           : merged AXIS master, zero-latency mux on registered state
//   drain_cycles       : idle cycles inserted before a config burst
//   cfg_busy, arb_state: status
//   MENSHEN_ARB_STATS_EN adds data_pkt_cnt, cfg_pkt_cnt, drain_cyc_cnt
module menshen_cfg_arbiter
  import menshen_arb_pkg::*;
#(
  parameter int DATA_W        = 512,
  parameter int KEEP_W        = DATA_W/8,
  parameter int USER_W        = 128,
  parameter int MAX_CFG_BURST = 4,
  parameter int CNT_W         = 32
) (
  input  logic              axis_aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_data_tdata,
  input  logic [KEEP_W-1:0] s_data_tkeep,
  input  logic [USER_W-1:0] s_data_tuser,
  input  logic              s_data_tvalid,
  input  logic              s_data_tlast,
  output logic              s_data_tready,
  input  logic [DATA_W-1:0] s_cfg_tdata,
  input  logic [KEEP_W-1:0] s_cfg_tkeep,
  input  logic [USER_W-1:0] s_cfg_tuser,
  input  logic              s_cfg_tvalid,
  input  logic              s_cfg_tlast,
  output logic              s_cfg_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  input  logic [15:0]       drain_cycles,
  output logic              cfg_busy,
  output logic [1:0]        arb_state
`ifdef MENSHEN_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  data_pkt_cnt,
  output logic [CNT_W-1:0]  cfg_pkt_cnt,
  output logic [CNT_W-1:0]  drain_cyc_cnt
`endif
);
  localparam int BW = $clog2(MAX_CFG_BURST + 1);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_CFG_BURST);
  arb_state_t state_q, state_d;
  logic [15:0] drain_q, drain_d;
  logic [BW-1:0] burst_q, burst_d;
  logic sel_data, sel_cfg, last_hs, decide;
  assign sel_data = state_q == DATA;
  assign sel_cfg  = state_q == CFG;
  always_comb begin
    m_axis_tvalid = sel_data ? s_data_tvalid : sel_cfg ? s_cfg_tvalid : 1'b0;
    m_axis_tdata  = sel_data ? s_data_tdata : sel_cfg ? s_cfg_tdata : '0;
    m_axis_tkeep  = sel_data ? s_data_tkeep : sel_cfg ? s_cfg_tkeep : '0;
    m_axis_tuser  = sel_data ? s_data_tuser : sel_cfg ? s_cfg_tuser : '0;
    m_axis_tlast  = sel_data ? s_data_tlast : sel_cfg ? s_cfg_tlast : 1'b0;
    s_data_tready = sel_data & m_axis_tready;
    s_cfg_tready  = sel_cfg & m_axis_tready;
  end
  // m_axis_tvalid is only ever high in DATA/CFG, so last_hs marks a packet boundary there
  assign last_hs = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign decide  = (state_q == IDLE) | last_hs;
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    burst_d = burst_q;
    if (state_q == DRAIN) begin
      drain_d = drain_q - 16'd1;
      if (drain_q == 16'd0) begin
        state_d = CFG;
        drain_d = drain_q;
        burst_d = BW'(1);
      end
    end else if (decide) begin
      if (state_q != CFG && s_cfg_tvalid) begin
        state_d = drain_cycles == 16'd0 ? CFG : DRAIN;
        drain_d = drain_cycles == 16'd0 ? drain_q : drain_cycles - 16'd1;
        burst_d = drain_cycles == 16'd0 ? BW'(1) : burst_q;
      end else if (state_q == CFG && s_cfg_tvalid && (burst_q < MAX_B || !s_data_tvalid)) begin
        state_d = CFG;
        burst_d = burst_q < MAX_B ? burst_q + BW'(1) : burst_q;
      end else begin
        state_d = s_data_tvalid ? DATA : IDLE;
        burst_d = '0;
      end
    end
  end
  always_ff @(posedge axis_aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      drain_q <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      burst_q <= burst_d;
    end
  end
  assign cfg_busy  = (state_q == DRAIN) | sel_cfg;
  assign arb_state = state_q;
`ifdef MENSHEN_ARB_STATS_EN
  menshen_arb_stats #(.CNT_W(CNT_W)) u_stats (
    .clk          (axis_aclk),
    .rst_n        (aresetn),
    .data_last    (sel_data & last_hs),
    .cfg_last     (sel_cfg & last_hs),
    .drain        (state_q == DRAIN),
    .data_pkt_cnt (data_pkt_cnt),
    .cfg_pkt_cnt  (cfg_pkt_cnt),
    .drain_cyc_cnt(drain_cyc_cnt)
  );
`endif
endmodule

// File: tb/tb_menshen_cfg_arbiter.sv
// tb_menshen_cfg_arbiter: directed and randomized check of menshen_cfg_arbiter against a packet-queue model
module tb_menshen_cfg_arbiter;
  localparam int DW = 512, KW = 64, UW = 128, MAXB = 4, CW = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [DW-1:0] s_data_tdata, s_cfg_tdata, m_axis_tdata;
  logic [KW-1:0] s_data_tkeep, s_cfg_tkeep, m_axis_tkeep;
  logic [UW-1:0] s_data_tuser, s_cfg_tuser, m_axis_tuser;
  logic s_data_tvalid, s_data_tlast, s_data_tready;
  logic s_cfg_tvalid, s_cfg_tlast, s_cfg_tready;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [15:0] drain_cycles;
  logic cfg_busy;
  logic [1:0] arb_state;
`ifdef MENSHEN_ARB_STATS_EN
  logic [CW-1:0] data_pkt_cnt, cfg_pkt_cnt, drain_cyc_cnt;
`endif
  always #5 clk = ~clk;
  menshen_cfg_arbiter #(.DATA_W(DW), .KEEP_W(KW), .USER_W(UW), .MAX_CFG_BURST(MAXB), .CNT_W(CW)) dut (
    .axis_aclk(clk), .aresetn(rst_n),
    .s_data_tdata(s_data_tdata), .s_data_tkeep(s_data_tkeep), .s_data_tuser(s_data_tuser),
    .s_data_tvalid(s_data_tvalid), .s_data_tlast(s_data_tlast), .s_data_tready(s_data_tready),
    .s_cfg_tdata(s_cfg_tdata), .s_cfg_tkeep(s_cfg_tkeep), .s_cfg_tuser(s_cfg_tuser),
    .s_cfg_tvalid(s_cfg_tvalid), .s_cfg_tlast(s_cfg_tlast), .s_cfg_tready(s_cfg_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .drain_cycles(drain_cycles), .cfg_busy(cfg_busy), .arb_state(arb_state)
`ifdef MENSHEN_ARB_STATS_EN
    , .data_pkt_cnt(data_pkt_cnt), .cfg_pkt_cnt(cfg_pkt_cnt), .drain_cyc_cnt(drain_cyc_cnt)
`endif
  );
  int n_checks = 0, n_fail = 0, cyc = 0;
  logic [DW-1:0] d_dat[$], c_dat[$];
  bit d_lst[$], c_lst[$];
  int owner, gap, burst;
  int exp_dcnt, exp_ccnt, exp_gcnt;
  int hs_cyc[$], hs_src[$];
  bit hs_lst[$];
  bit saw_busy, saw_dready;
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int k = 0; k < DW/32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction
  task automatic drive();
    s_data_tvalid = d_dat.size() > 0;
    s_data_tdata  = s_data_tvalid ? d_dat[0] : '0;
    s_data_tlast  = s_data_tvalid && d_lst[0];
    s_data_tkeep  = ~s_data_tdata[KW-1:0];
    s_data_tuser  = s_data_tdata[DW-1 -: UW];
    s_cfg_tvalid  = c_dat.size() > 0;
    s_cfg_tdata   = s_cfg_tvalid ? c_dat[0] : '0;
    s_cfg_tlast   = s_cfg_tvalid && c_lst[0];
    s_cfg_tkeep   = ~s_cfg_tdata[KW-1:0];
    s_cfg_tuser   = s_cfg_tdata[DW-1 -: UW];
  endtask
  task automatic push(input bit is_cfg, input int len);
    for (int i = 0; i < len; i++) begin
      if (is_cfg) begin
        c_dat.push_back(rand_word());
        c_lst.push_back(i == len - 1);
      end else begin
        d_dat.push_back(rand_word());
        d_lst.push_back(i == len - 1);
      end
    end
    drive();
  endtask
  task automatic clear_log();
    hs_cyc.delete(); hs_src.delete(); hs_lst.delete();
    saw_busy = 0; saw_dready = 0;
  endtask
  // one clock: enter at posedge+1 with inputs set, compare at negedge, advance model after the edge
  task automatic step();
    bit dv, cv, ev, lst, hs;
    int no, ng, nb;
    logic [DW-1:0] w;
    logic [KW-1:0] ek;
    #4;
    dv = d_dat.size() > 0;
    cv = c_dat.size() > 0;
    ev = (owner == 1 && dv) || (owner == 3 && cv);
    w  = (owner == 1 && dv) ? d_dat[0] : (owner == 3 && cv) ? c_dat[0] : '0;
    lst = ev && (owner == 1 ? d_lst[0] : c_lst[0]);
    ek = (owner == 1 || owner == 3) ? ~w[KW-1:0] : '0;
    check("state", arb_state, owner);
    check("cfg_busy", cfg_busy, owner >= 2);
    check("m_tvalid", m_axis_tvalid, ev);
    check("m_tdata", m_axis_tdata, w);
    check("m_tkeep", m_axis_tkeep, ek);
    check("m_tuser", m_axis_tuser, w[DW-1 -: UW]);
    check("m_tlast", m_axis_tlast, lst);
    check("data_tready", s_data_tready, owner == 1 && m_axis_tready);
    check("cfg_tready", s_cfg_tready, owner == 3 && m_axis_tready);
`ifdef MENSHEN_ARB_STATS_EN
    check("data_pkt_cnt", data_pkt_cnt, exp_dcnt);
    check("cfg_pkt_cnt", cfg_pkt_cnt, exp_ccnt);
    check("drain_cyc_cnt", drain_cyc_cnt, exp_gcnt);
`endif
    if (cfg_busy) saw_busy = 1;
    if (s_data_tready) saw_dready = 1;
    hs = ev && m_axis_tready;
    no = owner; ng = gap; nb = burst;
    if (owner == 2) begin
      ng = gap - 1;
      if (ng == 0) begin no = 3; nb = 1; end
    end else if (owner == 0 || (hs && lst)) begin
      if (owner != 3 && cv) begin
        if (drain_cycles == 0) begin no = 3; nb = 1; end
        else begin no = 2; ng = drain_cycles; end
      end else if (owner == 3 && cv && (burst < MAXB || !dv)) begin
        no = 3; nb = (burst < MAXB) ? burst + 1 : MAXB;
      end else begin
        no = dv ? 1 : 0; nb = 0;
      end
    end
    @(posedge clk);
    #1;
    if (hs && lst) begin
      if (owner == 1) exp_dcnt++; else exp_ccnt++;
    end
    if (owner == 2) exp_gcnt++;
    if (hs) begin
      if (owner == 1) begin void'(d_dat.pop_front()); void'(d_lst.pop_front()); end
      else begin void'(c_dat.pop_front()); void'(c_lst.pop_front()); end
      hs_cyc.push_back(cyc); hs_src.push_back(owner); hs_lst.push_back(lst);
    end
    owner = no; gap = ng; burst = nb;
    cyc++;
    drive();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_state", arb_state, 0);
    check("rst_busy", cfg_busy, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tdata", m_axis_tdata, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_data_tready", s_data_tready, 0);
    check("rst_cfg_tready", s_cfg_tready, 0);
`ifdef MENSHEN_ARB_STATS_EN
    check("rst_data_cnt", data_pkt_cnt, 0);
    check("rst_cfg_cnt", cfg_pkt_cnt, 0);
    check("rst_drain_cnt", drain_cyc_cnt, 0);
`endif
    d_dat.delete(); d_lst.delete(); c_dat.delete(); c_lst.delete();
    drive();
    owner = 0; gap = 0; burst = 0;
    exp_dcnt = 0; exp_ccnt = 0; exp_gcnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
  endtask
  function automatic int first_hs(input int src, input bit want_last);
    for (int i = 0; i < hs_cyc.size(); i++)
      if (hs_src[i] == src && (!want_last || hs_lst[i])) return hs_cyc[i];
    return -1000;
  endfunction
  initial begin
    int ord[$];
    int exp_ord[7];
    int cnt;
    bit pat[10];
    m_axis_tready = 1'b0;
    drain_cycles = 16'd0;
    drive();
    @(posedge clk);
    #1;
    do_reset();
    // three 2-beat data packets stream with no bubbles
    m_axis_tready = 1'b1; drain_cycles = 16'd3;
    repeat (3) push(0, 2);
    repeat (9) step();
    check("t1_beats", hs_cyc.size(), 6);
    check("t1_span", hs_cyc[5] - hs_cyc[0], 5);
    check("t1_busy", saw_busy, 0);
    // config arrives mid data packet with a 5-cycle drain
    do_reset();
    m_axis_tready = 1'b1; drain_cycles = 16'd5;
    push(0, 3);
    step(); step();
    push(1, 2);
    repeat (14) step();
    check("t2_gap", first_hs(3, 0) - first_hs(1, 1) - 1, 5);
    check("t2_drain_cnt", exp_gcnt, 5);
    // six config packets against pending data: burst limit lets one data packet through
    do_reset();
    m_axis_tready = 1'b1; drain_cycles = 16'd2;
    repeat (6) push(1, 1 + int'($urandom % 2));
    push(0, 2);
    repeat (40) step();
    ord.delete();
    for (int i = 0; i < hs_cyc.size(); i++) if (hs_lst[i]) ord.push_back(hs_src[i]);
    exp_ord = '{3, 3, 3, 3, 1, 3, 3};
    check("t3_npkts", ord.size(), 7);
    for (int i = 0; i < 7; i++) check($sformatf("t3_order%0d", i), ord[i], exp_ord[i]);
    // zero drain: config follows the data tlast with no gap
    do_reset();
    m_axis_tready = 1'b1; drain_cycles = 16'd0;
    push(0, 2);
    step();
    push(1, 2);
    repeat (6) step();
    check("t4_next", first_hs(3, 0), first_hs(1, 1) + 1);
    // backpressure in the middle of a config packet
    do_reset();
    drain_cycles = 16'd1;
    push(1, 4);
    push(0, 1);
    pat = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    for (int i = 0; i < 10; i++) begin
      m_axis_tready = pat[i];
      step();
    end
    cnt = 0;
    for (int i = 0; i < hs_src.size(); i++) if (hs_src[i] == 3) cnt++;
    check("t5_cfg_beats", cnt, 4);
    check("t5_data_tready", saw_dready, 0);
    // reset during beat 2 of a 3-beat packet (checked inside do_reset)
    do_reset();
    m_axis_tready = 1'b1; drain_cycles = 16'd0;
    push(0, 3);
    step(); step();
    check("t6_mid_pkt", m_axis_tvalid, 1);
    do_reset();
    step();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 8 == 0 && d_dat.size() < 16) push(0, 1 + int'($urandom % 4));
      if ($urandom % 10 == 0 && c_dat.size() < 16) push(1, 1 + int'($urandom % 3));
      if ($urandom % 64 == 0) drain_cycles = 16'($urandom % 5);
      m_axis_tready = ($urandom % 4) != 0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
